// File: rtl/scm_march_bist_ctrl.sv
// rtl/scm_march_bist_ctrl.sv - March C- BIST sequencer driving the test port of a wrapped SCM
module scm_march_bist_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  bist_o,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    output logic [NUM_BYTE-1:0]   BE_T,
    input  logic [DATA_WIDTH-1:0] Q_T,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  bg_q, bg_d;
    logic                  csn_d, wen_d, bist_d, busy_d, done_d;
    logic                  clear_fail;
    logic                  issue;
    logic                  last_at_addr, addr_end, is_wr;
    logic [2:0]            elem_inc;

    logic                  exp_valid_q;
    logic                  exp_bg_q;
    logic [2:0]            exp_elem_q;
    logic [ADDR_WIDTH-1:0] exp_addr_q;
    logic                  mismatch;

    // M3/M4 walk downwards; M1..M4 are read-then-write elements
    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic two_op(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic read_bg(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    function automatic logic write_bg(input logic [2:0] e);
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    assign BE_T = '1;
    assign D_T  = {DATA_WIDTH{bg_q}};

    assign last_at_addr = !(two_op(elem_q) && !phase_q);
    assign addr_end     = is_down(elem_q) ? (A_T == '0) : (A_T == ADDR_MAX);
    assign elem_inc     = elem_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        phase_d    = phase_q;
        addr_d     = A_T;
        bg_d       = bg_q;
        csn_d      = 1'b1;
        wen_d      = 1'b1;
        bist_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = done_o;
        clear_fail = 1'b0;
        issue      = 1'b0;
        is_wr      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d    = S_RUN;
                    issue      = 1'b1;
                    elem_d     = 3'd0;
                    phase_d    = 1'b0;
                    addr_d     = '0;
                    clear_fail = 1'b1;
                    done_d     = 1'b0;
                end
            end
            S_RUN: begin
                if (!last_at_addr) begin
                    issue   = 1'b1;
                    phase_d = 1'b1;
                end else if (!addr_end) begin
                    issue   = 1'b1;
                    phase_d = 1'b0;
                    addr_d  = is_down(elem_q) ? A_T - 1'b1 : A_T + 1'b1;
                end else if (elem_q == 3'd5) begin
                    state_d = S_DRAIN;
                    bist_d  = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    issue   = 1'b1;
                    elem_d  = elem_inc;
                    phase_d = 1'b0;
                    addr_d  = is_down(elem_inc) ? ADDR_MAX : '0;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            is_wr  = (elem_d == 3'd0) || (two_op(elem_d) && phase_d);
            csn_d  = 1'b0;
            wen_d  = !is_wr;
            bg_d   = is_wr ? write_bg(elem_d) : read_bg(elem_d);
            bist_d = 1'b1;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            elem_q  <= 3'd0;
            phase_q <= 1'b0;
            A_T     <= '0;
            bg_q    <= 1'b0;
            CSN_T   <= 1'b1;
            WEN_T   <= 1'b1;
            bist_o  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
            A_T     <= addr_d;
            bg_q    <= bg_d;
            CSN_T   <= csn_d;
            WEN_T   <= wen_d;
            bist_o  <= bist_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
        end
    end

    // The read on the port is sampled by the SCM this edge; its data returns next cycle
    assign mismatch = exp_valid_q && (Q_T != {DATA_WIDTH{exp_bg_q}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid_q <= 1'b0;
            exp_bg_q    <= 1'b0;
            exp_elem_q  <= 3'd0;
            exp_addr_q  <= '0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= 3'd0;
        end else begin
            exp_valid_q <= !CSN_T && WEN_T;
            exp_bg_q    <= bg_q;
            exp_elem_q  <= elem_q;
            exp_addr_q  <= A_T;
            if (clear_fail) begin
                fail_o      <= 1'b0;
                fail_addr_o <= '0;
                fail_elem_o <= 3'd0;
            end else if (mismatch && !fail_o) begin
                fail_o      <= 1'b1;
                fail_addr_o <= exp_addr_q;
                fail_elem_o <= exp_elem_q;
            end
        end
    end

endmodule

// File: tb/tb_scm_march_bist_ctrl.sv
// tb/tb_scm_march_bist_ctrl.sv - randomized model-checked bench for scm_march_bist_ctrl
module tb_scm_march_bist_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int N  = 1 << AW;
    localparam int T  = 10 * N + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          bist_o, CSN_T, WEN_T, busy_o, done_o, fail_o;
    logic [AW-1:0] A_T, fail_addr_o;
    logic [DW-1:0] D_T;
    logic [DW-1:0] Q_T = '0;
    logic [NB-1:0] BE_T;
    logic [2:0]    fail_elem_o;

    scm_march_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .bist_o(bist_o),
        .CSN_T(CSN_T), .WEN_T(WEN_T), .A_T(A_T), .D_T(D_T), .BE_T(BE_T),
        .Q_T(Q_T), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o)
    );

    always #5 clk = ~clk;

    // Behavioural SCM with per-address stuck-at masks
    logic [DW-1:0] mem [N];
    logic [DW-1:0] sa0 [N];
    logic [DW-1:0] sa1 [N];

    always @(posedge clk) begin
        if (!CSN_T) begin
            if (!WEN_T) mem[A_T] <= (D_T & ~sa0[A_T]) | sa1[A_T];
            else        Q_T      <= (mem[A_T] & ~sa0[A_T]) | sa1[A_T];
        end
    end

    typedef struct {
        bit we;
        int addr;
        bit bg;
        int elem;
    } op_t;

    op_t ops[$];
    int  checks = 0;
    int  errors = 0;
    int  fail_idx;
    int  n_ops;
    int  m1_ops;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %h want %h", name, k, act, exp);
        end
    endtask

    function automatic void push_op(input bit we, input int a, input bit bg, input int e);
        op_t o;
        o.we = we; o.addr = a; o.bg = bg; o.elem = e;
        ops.push_back(o);
    endfunction

    // March C-: elements listed as (first-op, second-op) with read/write and background
    function automatic void build_march();
        int a;
        ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e == 3 || e == 4) ? N - 1 - i : i;
                case (e)
                    0: push_op(1, a, 0, e);
                    1, 3: begin push_op(0, a, 0, e); push_op(1, a, 1, e); end
                    2, 4: begin push_op(0, a, 1, e); push_op(1, a, 0, e); end
                    default: push_op(0, a, 0, e);
                endcase
            end
        end
    endfunction

    function automatic void predict();
        logic [DW-1:0] mm [N];
        logic [DW-1:0] rv;
        for (int i = 0; i < N; i++) mm[i] = '0;
        fail_idx = -1;
        for (int j = 0; j < ops.size(); j++) begin
            if (ops[j].we) begin
                mm[ops[j].addr] = ({DW{ops[j].bg}} & ~sa0[ops[j].addr]) | sa1[ops[j].addr];
            end else begin
                rv = (mm[ops[j].addr] & ~sa0[ops[j].addr]) | sa1[ops[j].addr];
                if (rv !== {DW{ops[j].bg}} && fail_idx < 0) fail_idx = j;
            end
        end
    endfunction

    function automatic void clear_faults();
        for (int i = 0; i < N; i++) begin sa0[i] = '0; sa1[i] = '0; end
    endfunction

    function automatic logic [63:0] pack(input logic b, input logic c, input logic w, input logic [AW-1:0] a,
                                         input logic [DW-1:0] d, input logic [NB-1:0] be,
                                         input logic bu, input logic dn, input logic f);
        return {17'd0, b, c, w, a, d, be, bu, dn, f};
    endfunction

    // Runs one march from a start pulse; stops after cycle abort_at if that is below T
    task automatic run_march(input int extra_start_at, input int abort_at);
        logic [63:0] exp_v, act_v;
        op_t o;
        bit f_exp;
        predict();
        n_ops = 0;
        m1_ops = 0;
        @(negedge clk);
        start_i = 1'b1;
        for (int k = 1; k <= T; k++) begin
            @(posedge clk);
            #1 start_i = (k == extra_start_at);
            @(negedge clk);
            if (!CSN_T) n_ops++;
            if (!CSN_T && k >= 33 && k <= 96) m1_ops++;
            f_exp = (fail_idx >= 0) && (k >= fail_idx + 3);
            if (k <= 10 * N) begin
                o = ops[k-1];
                exp_v = pack(1, 0, !o.we, AW'(o.addr), o.we ? {DW{o.bg}} : '0, '1, 1, 0, f_exp);
                act_v = pack(bist_o, CSN_T, WEN_T, A_T, !WEN_T ? D_T : '0, BE_T, busy_o, done_o, fail_o);
            end else begin
                exp_v = pack(k == T - 1, 1, 1, '0, '0, '1, k == T - 1, k == T, f_exp);
                act_v = pack(bist_o, CSN_T, WEN_T, '0, '0, BE_T, busy_o, done_o, fail_o);
            end
            chk("cycle_outputs", k, act_v, exp_v);
            if (k == abort_at) return;
        end
        chk("fail_addr", T, 64'(fail_addr_o), fail_idx >= 0 ? 64'(ops[fail_idx].addr) : 64'd0);
        chk("fail_elem", T, 64'(fail_elem_o), fail_idx >= 0 ? 64'(ops[fail_idx].elem) : 64'd0);
    endtask

    initial begin
        int ra;
        logic [DW-1:0] rm;
        clear_faults();
        for (int i = 0; i < N; i++) mem[i] = '0;
        build_march();
        chk("model_op_count", 0, 64'(ops.size()), 64'd320);
        chk("model_first_op", 0, {31'd0, ops[0].we, ops[0].addr}, {31'd0, 1'b1, 32'd0});
        chk("model_last_op", 0, {31'd0, ops[319].we, ops[319].addr}, {31'd0, 1'b0, 32'd31});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 0, pack(bist_o, CSN_T, WEN_T, A_T, D_T, BE_T, busy_o, done_o, fail_o),
            pack(0, 1, 1, '0, '0, '1, 0, 0, 0));
        chk("reset_fail_info", 0, 64'({fail_addr_o, fail_elem_o}), 64'd0);
        rst_n = 1'b1;

        run_march(0, T);
        chk("ops_issued", 1, 64'(n_ops), 64'd320);
        chk("m1_ops", 1, 64'(m1_ops), 64'd64);
        chk("clean_fail", 1, 64'(fail_o), 64'd0);

        sa0[5] = 32'h8;
        run_march(0, T);
        chk("sa0_b3_a5", 2, 64'({fail_o, fail_addr_o, fail_elem_o}), {55'd0, 1'b1, 5'd5, 3'd2});

        clear_faults();
        sa1[5] = '1;
        run_march(0, T);
        chk("sa1_a5", 3, 64'({fail_o, fail_addr_o, fail_elem_o}), {55'd0, 1'b1, 5'd5, 3'd1});

        clear_faults();
        sa0[5] = 32'h8;
        sa0[9] = 32'h1;
        run_march(0, T);
        chk("keep_first", 4, 64'({fail_o, fail_addr_o, fail_elem_o}), {55'd0, 1'b1, 5'd5, 3'd2});

        clear_faults();
        run_march(100, T);
        chk("restart_clears", 5, 64'({done_o, fail_o}), 64'b10);

        for (int r = 0; r < 4; r++) begin
            clear_faults();
            ra = $urandom_range(0, N - 1);
            rm = ($urandom_range(0, 3) == 0) ? '1 : (32'd1 << $urandom_range(0, DW - 1));
            if ($urandom_range(0, 1) == 1) sa1[ra] = rm;
            else                           sa0[ra] = rm;
            run_march(0, T);
            chk("random_fail_seen", 6 + r, 64'(fail_o), 64'd1);
        end

        clear_faults();
        run_march(0, 150);
        rst_n = 1'b0;
        #1;
        chk("mid_run_reset", 150, pack(bist_o, CSN_T, WEN_T, A_T, D_T, BE_T, busy_o, done_o, fail_o),
            pack(0, 1, 1, '0, '0, '1, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        run_march(0, T);
        chk("post_reset_clean", 10, 64'({done_o, fail_o}), 64'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
